// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through all four input vectors, holds each for a settle
// window, samples the gate output and compares it against a latched truth table.
module gate_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] exp_tt,
   output logic       gut_a,
   output logic       gut_b,
   input  logic       gut_f,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_mask,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [5:0] PASS_LAST   = 6'(PASSES - 1);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [5:0] pcnt_q, pcnt_d;
   logic [7:0] settle_q, settle_d;
   logic [3:0] exp_q, exp_d;
   logic       gut_a_q, gut_a_d;
   logic       gut_b_q, gut_b_d;
   logic       pass_q, pass_d;
   logic [3:0] mask_q, mask_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] nxt_idx;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= 2'd0;
         pcnt_q   <= 6'd0;
         settle_q <= 8'd0;
         exp_q    <= 4'd0;
         gut_a_q  <= 1'b0;
         gut_b_q  <= 1'b0;
         pass_q   <= 1'b0;
         mask_q   <= 4'd0;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         pcnt_q   <= pcnt_d;
         settle_q <= settle_d;
         exp_q    <= exp_d;
         gut_a_q  <= gut_a_d;
         gut_b_q  <= gut_b_d;
         pass_q   <= pass_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pcnt_d   = pcnt_q;
      settle_d = settle_q;
      exp_d    = exp_q;
      gut_a_d  = gut_a_q;
      gut_b_d  = gut_b_q;
      pass_d   = pass_q;
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      nxt_idx  = idx_q + 2'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d    = exp_tt;
               mask_d   = 4'd0;
               cnt_d    = 8'd0;
               pass_d   = 1'b0;
               idx_d    = 2'd0;
               pcnt_d   = 6'd0;
               settle_d = 8'd0;
               gut_a_d  = 1'b0;
               gut_b_d  = 1'b0;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
               gut_a_d = 1'b0;
               gut_b_d = 1'b0;
               pass_d  = 1'b0;
            end else if (settle_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         SAMPLE: begin
            // Abort on the closing edge discards this sample as well as the done.
            if (abort) begin
               state_d = IDLE;
               gut_a_d = 1'b0;
               gut_b_d = 1'b0;
               pass_d  = 1'b0;
            end else begin
               if (gut_f != exp_q[idx_q]) begin
                  mask_d[idx_q] = 1'b1;
                  cnt_d         = sat_inc(cnt_q);
               end
               if (idx_q == 2'd3 && pcnt_q == PASS_LAST) begin
                  state_d = DONE;
                  gut_a_d = 1'b0;
                  gut_b_d = 1'b0;
                  pass_d  = (cnt_d == 8'd0);
               end else begin
                  idx_d    = nxt_idx;
                  if (idx_q == 2'd3) pcnt_d = pcnt_q + 6'd1;
                  gut_a_d  = nxt_idx[1];
                  gut_b_d  = nxt_idx[0];
                  settle_d = 8'd0;
                  state_d  = SETTLE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign gut_a    = gut_a_q;
   assign gut_b    = gut_b_q;
   assign busy     = (state_q == SETTLE) || (state_q == SAMPLE);
   assign done     = (state_q == DONE);
   assign pass     = pass_q;
   assign err_mask = mask_q;
   assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: a truth-table gate model drives gut_f and
// a result scoreboard is filled at start and drained at the done pulse.
module tb_gate_sweep_ctrl;

   typedef struct packed {
      logic       pass;
      logic [3:0] mask;
      logic [7:0] cnt;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0;
   logic [3:0] exp_tt = 4'd0, gate_tt = 4'd0;
   logic       gut_a, gut_b, gut_f, busy, done, pass;
   logic [3:0] err_mask;
   logic [7:0] err_cnt;

   logic       start1 = 1'b0;
   logic [3:0] exp_tt1 = 4'd0;
   logic       gut_a1, gut_b1, busy1, done1, pass1;
   logic [3:0] err_mask1;
   logic [7:0] err_cnt1;

   int   vectors = 0;
   int   miscompares = 0;
   res_t sb[$];

   always #5 clk = ~clk;

   assign gut_f = gate_tt[{gut_a, gut_b}];

   gate_sweep_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
      .gut_a(gut_a), .gut_b(gut_b), .gut_f(gut_f), .busy(busy), .done(done),
      .pass(pass), .err_mask(err_mask), .err_cnt(err_cnt)
   );

   gate_sweep_ctrl #(.SETTLE_CYCLES(1), .PASSES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .exp_tt(exp_tt1),
      .gut_a(gut_a1), .gut_b(gut_b1), .gut_f(1'b0), .busy(busy1), .done(done1),
      .pass(pass1), .err_mask(err_mask1), .err_cnt(err_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One run on the default instance (3 cycles per vector, done at cycle 12).
   // abort_k: cycle whose opening edge sees abort (-1 none); restart_k: cycle in
   // which a spurious start is driven (-1 none).
   task automatic sweep0(input logic [3:0] gtt, input int abort_k, input int restart_k);
      logic [3:0] et, m;
      logic [7:0] c;
      int         nvec;
      bit         fin;
      res_t       r;
      et   = 4'b1001;
      m    = 4'd0;
      c    = 8'd0;
      nvec = (abort_k < 0) ? 4 : (abort_k - 1) / 3;
      for (int i = 0; i < nvec; i++)
         if (gtt[i] != et[i]) begin
            m[i] = 1'b1;
            c++;
         end
      r.pass = (abort_k < 0) && (c == 8'd0);
      r.mask = m;
      r.cnt  = c;
      sb.push_back(r);

      gate_tt = gtt;
      @(negedge clk);
      start  = 1'b1;
      exp_tt = et;
      @(negedge clk);
      start  = 1'b0;
      exp_tt = ~et;
      fin    = 1'b0;
      for (int k = 0; k < 40 && !fin; k++) begin
         start = 1'b0;
         abort = 1'b0;
         if (abort_k >= 0 && k == abort_k) begin
            r = sb.pop_front();
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_gut", {gut_a, gut_b}, 0);
            chk("abort_pass", pass, 0);
            chk("abort_mask", err_mask, r.mask);
            chk("abort_cnt", err_cnt, r.cnt);
            fin = 1'b1;
         end else if (k == 12) begin
            r = sb.pop_front();
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_gut", {gut_a, gut_b}, 0);
            chk("pass", pass, r.pass);
            chk("err_mask", err_mask, r.mask);
            chk("err_cnt", err_cnt, r.cnt);
            fin = 1'b1;
         end else begin
            chk("vector", {gut_a, gut_b}, k / 3);
            chk("busy", busy, 1);
            chk("early_done", done, 0);
         end
         if (k == abort_k - 1) abort = 1'b1;
         if (k == restart_k) start = 1'b1;
         if (!fin) @(negedge clk);
      end
      chk("run_finished", fin, 1);
      if (!fin) r = sb.pop_front();
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         chk("after_done", done, 0);
         chk("after_busy", busy, 0);
         chk("hold_pass", pass, r.pass);
         chk("hold_mask", err_mask, r.mask);
         chk("hold_cnt", err_cnt, r.cnt);
      end
   endtask

   initial begin
      res_t r;
      bit   fin;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_mask", err_mask, 0);
      chk("rst_cnt", err_cnt, 0);
      chk("rst_gut", {gut_a, gut_b}, 0);
      chk("rst_busy3", busy1, 0);
      @(negedge clk);
      rst_n = 1'b1;

      sweep0(4'b1001, -1, -1);   // XNOR, clean
      sweep0(4'b1000, -1, -1);   // AND against XNOR expectation
      sweep0(4'b1001, -1, 6);    // spurious start during vector 2 settle
      sweep0(4'b1000, 6, -1);    // abort entering vector 2, partial results kept
      sweep0(4'b1001, -1, -1);   // normal run after abort

      // Asynchronous reset mid-sweep
      gate_tt = 4'b1000;
      @(negedge clk);
      start  = 1'b1;
      exp_tt = 4'b1001;
      @(negedge clk);
      start  = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_mask", err_mask, 4'b0001);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_mask", err_mask, 0);
      chk("mid_rst_cnt", err_cnt, 0);
      chk("mid_rst_gut", {gut_a, gut_b}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sweep0(4'b1001, -1, -1);

      // Gate output stuck at 0, three passes of 2-cycle vectors
      r.pass = 1'b0;
      r.mask = 4'b1001;
      r.cnt  = 8'd6;
      sb.push_back(r);
      @(negedge clk);
      start1  = 1'b1;
      exp_tt1 = 4'b1001;
      @(negedge clk);
      start1  = 1'b0;
      exp_tt1 = 4'b0000;
      fin     = 1'b0;
      for (int k = 0; k < 60 && !fin; k++) begin
         if (k == 24) begin
            r = sb.pop_front();
            chk("p3_done", done1, 1);
            chk("p3_busy", busy1, 0);
            chk("p3_pass", pass1, r.pass);
            chk("p3_mask", err_mask1, r.mask);
            chk("p3_cnt", err_cnt1, r.cnt);
            fin = 1'b1;
         end else begin
            chk("p3_vector", {gut_a1, gut_b1}, (k / 2) % 4);
            chk("p3_busy_run", busy1, 1);
            chk("p3_early_done", done1, 0);
            @(negedge clk);
         end
      end
      chk("p3_finished", fin, 1);
      @(negedge clk);
      chk("p3_after_done", done1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
